m_decoder_alu_stage: RTL and testbench

- Registered, buffered ALU decode stage between fetch and the ALU issue port.
- Decodes one instruction per accepted handshake into an s_control word plus an illegal flag.
- Results are held in a parametrised in-order FIFO, so decode is decoupled from ALU back-pressure.
- Provides pipeline flush, optional rotate support, and saturating decode/illegal event counters.

---
 rtl/m_decoder_alu_stage.sv | 216 +++++++++++++++++++++
 tb/tb_m_decoder_alu_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_decoder_alu_stage.sv
// ALU decode stage: decodes binop instructions into an ALU control word and
// buffers the results in a small in-order FIFO ahead of the ALU issue port.
package m_decoder_alu_pkg;
  typedef enum logic [1:0] {KIND_RRR = 2'd0, KIND_RRI, KIND_MEM, KIND_BRANCH} e_kind;

  typedef enum logic [4:0] {
    BINOP_ADD = 5'd0, BINOP_SUB, BINOP_AND, BINOP_OR, BINOP_XOR,
    BINOP_SHL, BINOP_SHR, BINOP_ASL, BINOP_ASR, BINOP_ROR, BINOP_ROL,
    BINOP_NOT, BINOP_NEG
  } e_binop;

  typedef enum logic [3:0] {
    CORE_OP_INVALID = 4'd0, CORE_OP_ADD, CORE_OP_AND, CORE_OP_XOR,
    CORE_OP_SHL, CORE_OP_SHR, CORE_OP_ASL, CORE_OP_ASR, CORE_OP_ROR, CORE_OP_ROL
  } e_core_op;

  typedef enum logic [1:0] {UNARY_OP_ID = 2'd0, UNARY_OP_NOT, UNARY_OP_NEG} e_unary_op;

  typedef enum logic [2:0] {
    SHIFT_SHL = 3'd0, SHIFT_SHR, SHIFT_ASL, SHIFT_ASR, SHIFT_ROR, SHIFT_ROL
  } e_shift_op;

  typedef struct packed {
    e_shift_op  op;
    logic [4:0] amount;
  } s_shift;

  typedef struct packed {
    e_core_op  core;
    e_unary_op pre_a;
    e_unary_op pre_b;
    s_shift    shift;
    e_unary_op post;
  } s_control;

  localparam s_control CONTROL_INVALID = '{
    core: CORE_OP_INVALID, pre_a: UNARY_OP_ID, pre_b: UNARY_OP_ID,
    shift: '{op: SHIFT_SHL, amount: 5'd0}, post: UNARY_OP_ID
  };
endpackage

// Shift sub-field decoder: shift flavour from the binop, amount from the low bits.
module m_decoder_shift
  import m_decoder_alu_pkg::*;
#(
  parameter int OPC_LSB = 23
) (
  input  e_kind       kind,
  input  logic [31:0] instruction,
  output s_shift      shift
);
  logic [4:0] opc;
  logic       unused_instr;

  assign opc          = instruction[OPC_LSB+4:OPC_LSB];
  assign unused_instr = ^instruction;

  always_comb begin
    shift = '{op: SHIFT_SHL, amount: 5'd0};
    if (kind == KIND_RRR) begin
      case (opc)
        BINOP_SHL: shift = '{op: SHIFT_SHL, amount: instruction[4:0]};
        BINOP_SHR: shift = '{op: SHIFT_SHR, amount: instruction[4:0]};
        BINOP_ASL: shift = '{op: SHIFT_ASL, amount: instruction[4:0]};
        BINOP_ASR: shift = '{op: SHIFT_ASR, amount: instruction[4:0]};
        BINOP_ROR: shift = '{op: SHIFT_ROR, amount: instruction[4:0]};
        BINOP_ROL: shift = '{op: SHIFT_ROL, amount: instruction[4:0]};
        default:   shift = '{op: SHIFT_SHL, amount: 5'd0};
      endcase
    end
  end
endmodule

module m_decoder_alu_stage
  import m_decoder_alu_pkg::*;
#(
  parameter int OPC_LSB    = 23,
  parameter int DEPTH      = 2,
  parameter int ENABLE_ROT = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  e_kind            kind,
  input  logic [31:0]      instruction,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output s_control         control,
  output logic             illegal,
  output logic [CNT_W-1:0] cnt_decoded,
  output logic [CNT_W-1:0] cnt_illegal
);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_FW = $clog2(DEPTH + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  s_shift     shift_p0;
  s_control   ctrl_p0;
  logic       ill_p0;
  logic [4:0] opc_p0;
  logic       vld_p0;

  s_control          ctrl_mem_p1 [DEPTH];
  logic              ill_mem_p1  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_p1;
  logic [PTR_W-1:0]  rd_ptr_p1;
  logic [CNT_FW-1:0] count_p1;
  logic              vld_p1;
  logic              pop_p1;

  // Stage p0: combinational decode of the presented instruction
  m_decoder_shift #(.OPC_LSB(OPC_LSB)) u_shift (
    .kind        (kind),
    .instruction (instruction),
    .shift       (shift_p0)
  );

  assign opc_p0 = instruction[OPC_LSB+4:OPC_LSB];

  always_comb begin
    ctrl_p0       = CONTROL_INVALID;
    ctrl_p0.shift = shift_p0;
    ill_p0        = 1'b0;
    case (opc_p0)
      BINOP_ADD: ctrl_p0.core = CORE_OP_ADD;
      BINOP_SUB: begin
        ctrl_p0.core  = CORE_OP_ADD;
        ctrl_p0.pre_b = UNARY_OP_NEG;
      end
      BINOP_AND: ctrl_p0.core = CORE_OP_AND;
      BINOP_OR: begin
        // De Morgan: a | b == ~(~a & ~b)
        ctrl_p0.core  = CORE_OP_AND;
        ctrl_p0.pre_a = UNARY_OP_NOT;
        ctrl_p0.pre_b = UNARY_OP_NOT;
        ctrl_p0.post  = UNARY_OP_NOT;
      end
      BINOP_XOR: ctrl_p0.core = CORE_OP_XOR;
      BINOP_SHL: ctrl_p0.core = CORE_OP_SHL;
      BINOP_SHR: ctrl_p0.core = CORE_OP_SHR;
      BINOP_ASL: ctrl_p0.core = CORE_OP_ASL;
      BINOP_ASR: ctrl_p0.core = CORE_OP_ASR;
      BINOP_ROR: begin
        ctrl_p0.core = CORE_OP_ROR;
        ill_p0       = (ENABLE_ROT == 0);
      end
      BINOP_ROL: begin
        ctrl_p0.core = CORE_OP_ROL;
        ill_p0       = (ENABLE_ROT == 0);
      end
      BINOP_NOT: begin
        ctrl_p0.core = CORE_OP_ADD;
        ctrl_p0.post = UNARY_OP_NOT;
      end
      BINOP_NEG: begin
        ctrl_p0.core = CORE_OP_ADD;
        ctrl_p0.post = UNARY_OP_NEG;
      end
      default: ill_p0 = 1'b1;
    endcase
    if (kind != KIND_RRR) ill_p0 = 1'b1;
    if (ill_p0) ctrl_p0 = CONTROL_INVALID;
  end

  // Full blocks the push even if the head leaves this cycle, keeping in_ready
  // independent of out_ready.
  assign in_ready = (count_p1 < CNT_FW'(DEPTH)) && !flush;
  assign vld_p0   = in_valid && in_ready;

  // Stage p1: FIFO storage and head presentation
  assign vld_p1 = (count_p1 != '0);
  assign pop_p1 = vld_p1 && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p1   <= '0;
      rd_ptr_p1   <= '0;
      count_p1    <= '0;
      cnt_decoded <= '0;
      cnt_illegal <= '0;
    end else if (flush) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      count_p1  <= '0;
    end else begin
      if (vld_p0) wr_ptr_p1 <= ptr_inc(wr_ptr_p1);
      if (pop_p1) rd_ptr_p1 <= ptr_inc(rd_ptr_p1);
      count_p1 <= count_p1 + CNT_FW'(vld_p0) - CNT_FW'(pop_p1);
      if (vld_p0) begin
        if (ill_p0) cnt_illegal <= sat_inc(cnt_illegal);
        else        cnt_decoded <= sat_inc(cnt_decoded);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      ctrl_mem_p1[wr_ptr_p1] <= ctrl_p0;
      ill_mem_p1[wr_ptr_p1]  <= ill_p0;
    end
  end

  assign out_valid = vld_p1;
  assign control   = vld_p1 ? ctrl_mem_p1[rd_ptr_p1] : CONTROL_INVALID;
  assign illegal   = vld_p1 && ill_mem_p1[rd_ptr_p1];
endmodule

// File: tb/tb_m_decoder_alu_stage.sv
// Bench for m_decoder_alu_stage: two configurations driven by shared stimulus,
// each checked every cycle against a queue-based reference model.
module tb_m_decoder_alu_stage;
  import m_decoder_alu_pkg::*;

  localparam int OPC = 23;
  localparam int M_DEPTH [2] = '{2, 3};
  localparam bit M_ROT   [2] = '{1'b1, 1'b0};
  localparam int M_MAX   [2] = '{65535, 15};

  typedef struct packed {
    logic     ill;
    s_control c;
  } s_entry;

  logic        clk, rst_n, in_valid, flush, out_ready;
  e_kind       kind;
  logic [31:0] instruction;

  logic        in_ready_a, out_valid_a, illegal_a;
  logic        in_ready_b, out_valid_b, illegal_b;
  s_control    control_a, control_b;
  logic [15:0] cnt_dec_a, cnt_ill_a;
  logic [3:0]  cnt_dec_b, cnt_ill_b;

  int n_assert = 0;
  int n_fail   = 0;

  s_entry mq [2][$];
  int     m_dec [2];
  int     m_ill [2];

  m_decoder_alu_stage #(.OPC_LSB(OPC), .DEPTH(2), .ENABLE_ROT(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .kind(kind), .instruction(instruction), .flush(flush),
    .out_valid(out_valid_a), .out_ready(out_ready), .control(control_a),
    .illegal(illegal_a), .cnt_decoded(cnt_dec_a), .cnt_illegal(cnt_ill_a)
  );

  m_decoder_alu_stage #(.OPC_LSB(OPC), .DEPTH(3), .ENABLE_ROT(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .kind(kind), .instruction(instruction), .flush(flush),
    .out_valid(out_valid_b), .out_ready(out_ready), .control(control_b),
    .illegal(illegal_b), .cnt_decoded(cnt_dec_b), .cnt_illegal(cnt_ill_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic s_control mk(input e_core_op co, input e_unary_op pa, input e_unary_op pb,
                                  input e_shift_op so, input logic [4:0] amt, input e_unary_op po);
    s_control c;
    c.core = co; c.pre_a = pa; c.pre_b = pb;
    c.shift.op = so; c.shift.amount = amt; c.post = po;
    return c;
  endfunction

  function automatic s_control inv_word();
    return mk(CORE_OP_INVALID, UNARY_OP_ID, UNARY_OP_ID, SHIFT_SHL, 5'd0, UNARY_OP_ID);
  endfunction

  function automatic logic [31:0] mkins(input e_binop op, input logic [31:0] r);
    logic [31:0] w;
    w = r;
    w[OPC+4:OPC] = op;
    return w;
  endfunction

  // Reference decode table: opcode -> (core, pre-A, pre-B, shift, post)
  function automatic s_entry ref_decode(input e_kind k, input logic [31:0] ins, input bit rot);
    s_entry e;
    logic [4:0] op;
    logic [4:0] amt;
    op  = ins[OPC+4:OPC];
    amt = ins[4:0];
    e.ill = 1'b0;
    e.c = mk(CORE_OP_ADD, UNARY_OP_ID, UNARY_OP_ID, SHIFT_SHL, 5'd0, UNARY_OP_ID);
    if (k != KIND_RRR) e.ill = 1'b1;
    else begin
      case (op)
        BINOP_ADD: ;
        BINOP_SUB: e.c.pre_b = UNARY_OP_NEG;
        BINOP_AND: e.c.core = CORE_OP_AND;
        BINOP_OR:  e.c = mk(CORE_OP_AND, UNARY_OP_NOT, UNARY_OP_NOT, SHIFT_SHL, 5'd0, UNARY_OP_NOT);
        BINOP_XOR: e.c.core = CORE_OP_XOR;
        BINOP_SHL: e.c = mk(CORE_OP_SHL, UNARY_OP_ID, UNARY_OP_ID, SHIFT_SHL, amt, UNARY_OP_ID);
        BINOP_SHR: e.c = mk(CORE_OP_SHR, UNARY_OP_ID, UNARY_OP_ID, SHIFT_SHR, amt, UNARY_OP_ID);
        BINOP_ASL: e.c = mk(CORE_OP_ASL, UNARY_OP_ID, UNARY_OP_ID, SHIFT_ASL, amt, UNARY_OP_ID);
        BINOP_ASR: e.c = mk(CORE_OP_ASR, UNARY_OP_ID, UNARY_OP_ID, SHIFT_ASR, amt, UNARY_OP_ID);
        BINOP_ROR: if (rot) e.c = mk(CORE_OP_ROR, UNARY_OP_ID, UNARY_OP_ID, SHIFT_ROR, amt, UNARY_OP_ID);
                   else e.ill = 1'b1;
        BINOP_ROL: if (rot) e.c = mk(CORE_OP_ROL, UNARY_OP_ID, UNARY_OP_ID, SHIFT_ROL, amt, UNARY_OP_ID);
                   else e.ill = 1'b1;
        BINOP_NOT: e.c.post = UNARY_OP_NOT;
        BINOP_NEG: e.c.post = UNARY_OP_NEG;
        default:   e.ill = 1'b1;
      endcase
    end
    if (e.ill) e.c = inv_word();
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int i, input bit rdy, input bit vld, input s_entry hd);
    string p;
    p = (i == 0) ? "a" : "b";
    chk({p, "_in_ready"},  (i == 0) ? 32'(in_ready_a)  : 32'(in_ready_b),  32'(rdy));
    chk({p, "_out_valid"}, (i == 0) ? 32'(out_valid_a) : 32'(out_valid_b), 32'(vld));
    chk({p, "_control"},   (i == 0) ? 32'(control_a)   : 32'(control_b),   32'(hd.c));
    chk({p, "_illegal"},   (i == 0) ? 32'(illegal_a)   : 32'(illegal_b),   32'(hd.ill));
    chk({p, "_cnt_decoded"}, (i == 0) ? 32'(cnt_dec_a) : 32'(cnt_dec_b), 32'(m_dec[i]));
    chk({p, "_cnt_illegal"}, (i == 0) ? 32'(cnt_ill_a) : 32'(cnt_ill_b), 32'(m_ill[i]));
  endtask

  // Check outputs at the falling edge, then advance the model over the rising edge.
  task automatic cycle();
    s_entry nxt [2];
    s_entry hd;
    bit push [2];
    bit pop [2];
    bit rdy;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rdy = (mq[i].size() < M_DEPTH[i]) && !flush;
      hd  = (mq[i].size() > 0) ? mq[i][0] : '{ill: 1'b0, c: inv_word()};
      check_dut(i, rdy, mq[i].size() > 0, hd);
      push[i] = in_valid && rdy;
      pop[i]  = (mq[i].size() > 0) && out_ready && !flush;
      nxt[i]  = ref_decode(kind, instruction, M_ROT[i]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (flush) mq[i].delete();
      else begin
        if (pop[i]) void'(mq[i].pop_front());
        if (push[i]) begin
          mq[i].push_back(nxt[i]);
          if (nxt[i].ill) begin if (m_ill[i] < M_MAX[i]) m_ill[i]++; end
          else            begin if (m_dec[i] < M_MAX[i]) m_dec[i]++; end
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_dec[i] = 0;
      m_ill[i] = 0;
    end
  endtask

  task automatic check_reset_now(input string tag);
    chk({tag, "_a_out_valid"}, 32'(out_valid_a), 32'd0);
    chk({tag, "_b_out_valid"}, 32'(out_valid_b), 32'd0);
    chk({tag, "_a_in_ready"},  32'(in_ready_a),  32'd1);
    chk({tag, "_b_in_ready"},  32'(in_ready_b),  32'd1);
    chk({tag, "_a_cnt_dec"},   32'(cnt_dec_a),   32'd0);
    chk({tag, "_b_cnt_dec"},   32'(cnt_dec_b),   32'd0);
    chk({tag, "_b_cnt_ill"},   32'(cnt_ill_b),   32'd0);
    chk({tag, "_a_control"},   32'(control_a),   32'(inv_word()));
    chk({tag, "_a_illegal"},   32'(illegal_a),   32'd0);
  endtask

  task automatic drive(input bit v, input e_binop op, input bit rdy);
    in_valid    = v;
    kind        = KIND_RRR;
    instruction = mkins(op, $urandom);
    out_ready   = rdy;
    flush       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    kind = KIND_RRR; instruction = '0;
    model_reset();
    #12;
    check_reset_now("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SUB decode with one-cycle latency
    drive(1'b1, BINOP_SUB, 1'b1);
    cycle();
    chk("sub_out_valid", 32'(out_valid_a), 32'd1);
    chk("sub_control", 32'(control_a),
        32'(mk(CORE_OP_ADD, UNARY_OP_ID, UNARY_OP_NEG, SHIFT_SHL, 5'd0, UNARY_OP_ID)));
    chk("sub_illegal", 32'(illegal_a), 32'd0);
    chk("sub_cnt_decoded", 32'(cnt_dec_a), 32'd1);
    in_valid = 1'b0;
    cycle();

    // Back-pressure: full FIFO blocks the third push, then drains in order
    drive(1'b1, BINOP_ADD, 1'b0);
    cycle();
    cycle();
    chk("full_in_ready", 32'(in_ready_a), 32'd0);
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    chk("bp_cnt_decoded", 32'(cnt_dec_a), 32'd4);

    // Rotate disabled on dut_b: ROL is illegal, XOR follows in order
    drive(1'b1, BINOP_ROL, 1'b0);
    cycle();
    instruction = mkins(BINOP_XOR, $urandom);
    cycle();
    chk("rol_b_control", 32'(control_b), 32'(inv_word()));
    chk("rol_b_illegal", 32'(illegal_b), 32'd1);
    chk("rol_b_cnt_illegal", 32'(cnt_ill_b), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("xor_b_core", 32'(control_b.core), 32'(CORE_OP_XOR));
    chk("xor_b_illegal", 32'(illegal_b), 32'd0);
    for (int k = 0; k < 3; k++) cycle();

    // Flush with a simultaneous push and pop
    drive(1'b1, BINOP_AND, 1'b0);
    cycle();
    cycle();
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_a_out_valid", 32'(out_valid_a), 32'd0);
    chk("flush_b_out_valid", 32'(out_valid_b), 32'd0);
    cycle();

    // Saturation of the 4-bit counter
    drive(1'b1, BINOP_ADD, 1'b1);
    for (int k = 0; k < 20; k++) cycle();
    in_valid = 1'b0;
    chk("sat_b_cnt_decoded", 32'(cnt_dec_b), 32'd15);
    cycle();
    cycle();

    // Asynchronous reset while full, then immediate acceptance after release
    drive(1'b1, BINOP_XOR, 1'b0);
    for (int k = 0; k < 3; k++) cycle();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_now("async_rst");
    model_reset();
    #1 rst_n = 1'b1;
    drive(1'b1, BINOP_NEG, 1'b1);
    cycle();
    chk("post_rst_out_valid", 32'(out_valid_a), 32'd1);
    chk("post_rst_cnt_decoded", 32'(cnt_dec_a), 32'd1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      kind        = ($urandom_range(0, 7) < 6) ? KIND_RRR : e_kind'($urandom_range(0, 3));
      instruction = $urandom;
      instruction[OPC+4:OPC] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                           : 5'($urandom_range(0, 13));
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 24) == 0);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
